// File: rtl/datapath_hz.sv
// datapath_hz: five-stage RV32I-style datapath with E-stage forwarding, load-use stall and redirect flush
module datapath_hz #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit              HAZ_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instrF,
  input  logic [XLEN-1:0] readdataM,
  input  logic            reg_writeD,
  input  logic [1:0]      result_srcD,
  input  logic            mem_writeD,
  input  logic            branchD,
  input  logic            jumpD,
  input  logic            jalrD,
  input  logic [2:0]      alu_controlD,
  input  logic            alu_srcD,
  input  logic [1:0]      imm_srcD,
  output logic [XLEN-1:0] pcF,
  output logic [31:0]     instrD,
  output logic            mem_writeM,
  output logic [XLEN-1:0] aluresultM,
  output logic [XLEN-1:0] writedataM,
  output logic            stall,
  output logic            flush
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int SW = $clog2(XLEN);

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write, branch, jump, jalr;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [XLEN-1:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]      rs1, rs2, rd;
  } de_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [XLEN-1:0] alu, wd, pc4;
    logic [4:0]      rd;
  } em_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu, rdata, pc4;
    logic [4:0]      rd;
  } mw_t;

  de_t d, e;
  em_t m_next, m;
  mw_t w_next, w;
  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] pcD, pc4D, rd1D, rd2D, immD, resultW, fwd_m, srca, wdE, srcb, aluE, targetE;
  logic [31:0] ext;
  logic [4:0] rs1D, rs2D;
  logic fa_m, fa_w, fb_m, fb_w, pcsrcE;

  assign rs1D = instrD[19:15];
  assign rs2D = instrD[24:20];
  assign resultW = w.result_src == 2'b01 ? w.rdata : w.result_src == 2'b10 ? w.pc4 : w.alu;
  // x0 reads zero; a same-cycle W write to the read register passes straight through
  assign rd1D = ~|rs1D ? '0 : (w.reg_write && w.rd == rs1D) ? resultW : rf[rs1D];
  assign rd2D = ~|rs2D ? '0 : (w.reg_write && w.rd == rs2D) ? resultW : rf[rs2D];
  assign ext = imm_srcD == 2'b00 ? {{20{instrD[31]}}, instrD[31:20]} :
               imm_srcD == 2'b01 ? {{20{instrD[31]}}, instrD[31:25], instrD[11:7]} :
               imm_srcD == 2'b10 ? {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0} :
                                   {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
  assign immD = XLEN'(signed'(ext));
  assign d = {reg_writeD, result_srcD, mem_writeD, branchD, jumpD, jalrD, alu_controlD, alu_srcD,
              rd1D, rd2D, pcD, pc4D, immD, rs1D, rs2D, instrD[11:7]};

  // a link-writing instruction in M forwards pc+4, anything else its ALU result
  assign fwd_m = m.result_src == 2'b10 ? m.pc4 : m.alu;
  assign fa_m = HAZ_EN && m.reg_write && |m.rd && m.rd == e.rs1;
  assign fa_w = HAZ_EN && w.reg_write && |w.rd && w.rd == e.rs1;
  assign fb_m = HAZ_EN && m.reg_write && |m.rd && m.rd == e.rs2;
  assign fb_w = HAZ_EN && w.reg_write && |w.rd && w.rd == e.rs2;
  assign srca = fa_m ? fwd_m : fa_w ? resultW : e.rd1;
  assign wdE = fb_m ? fwd_m : fb_w ? resultW : e.rd2;
  assign srcb = e.alu_src ? e.imm : wdE;

  // ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
  always_comb
    case (e.alu_control)
      3'b000:  aluE = srca + srcb;
      3'b001:  aluE = srca - srcb;
      3'b010:  aluE = srca & srcb;
      3'b011:  aluE = srca | srcb;
      3'b100:  aluE = srca ^ srcb;
      3'b101:  aluE = XLEN'($signed(srca) < $signed(srcb));
      3'b110:  aluE = srca << srcb[SW-1:0];
      default: aluE = srca >> srcb[SW-1:0];
    endcase

  assign pcsrcE = (e.branch && aluE == '0) || e.jump || e.jalr;
  assign targetE = e.jalr ? aluE & ~XLEN'(1) : e.pc + e.imm;
  assign stall = HAZ_EN && e.result_src == 2'b01 && |e.rd && (e.rd == rs1D || e.rd == rs2D);
  assign flush = HAZ_EN && pcsrcE;
  assign m_next = {e.reg_write, e.result_src, e.mem_write, aluE, wdE, e.pc4, e.rd};
  assign w_next = {m.reg_write, m.result_src, m.alu, readdataM, m.pc4, m.rd};
  assign mem_writeM = m.mem_write;
  assign aluresultM = m.alu;
  assign writedataM = m.wd;

  // fetch PC: a redirect beats a stall, a stall holds
  always_ff @(posedge clk or negedge reset)
    if (!reset) pcF <= RESET_PC;
    else if (pcsrcE) pcF <= targetE;
    else if (!stall) pcF <= pcF + XLEN'(4);

  // F/D register: NOP on flush, hold on stall
  always_ff @(posedge clk or negedge reset)
    if (!reset || flush) begin
      instrD <= NOP;
      pcD <= '0;
      pc4D <= '0;
    end else if (!stall) begin
      instrD <= instrF;
      pcD <= pcF;
      pc4D <= pcF + XLEN'(4);
    end

  // D/E register: bubble on stall or flush
  always_ff @(posedge clk or negedge reset)
    if (!reset) e <= '0;
    else e <= (stall || flush) ? '0 : d;

  // E/M and M/W registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      m <= '0;
      w <= '0;
    end else begin
      m <= m_next;
      w <= w_next;
    end

  // register file write; contents survive reset, only in-flight writes are discarded
  always_ff @(posedge clk)
    if (w.reg_write && |w.rd) rf[w.rd] <= resultW;
endmodule

// File: tb/tb_datapath_hz.sv
// tb_datapath_hz: program-level checks of datapath_hz with a bench-side controller, imem and dmem
module tb_datapath_hz;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic rw;
    logic [1:0] rs;
    logic mw, br, j, jr;
    logic [2:0] ac;
    logic as;
    logic [1:0] is;
  } ctl_t;

  typedef struct {
    logic [6:0] f7;
    logic [2:0] f3;
    logic [11:0] a, b;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] imem [0:127];
  logic [31:0] dm1 [0:127];
  logic [31:0] dm0 [0:127];
  logic [31:0] instr1, instr0, pc1, pc0, id1, id0, ar1, ar0, wd1, wd0, rdata1, rdata0;
  logic mw1, mw0, st1, st0, fl1, fl0, pfl;
  ctl_t c1, c0;
  logic [31:0] pc_fl;
  int total = 0, bad = 0, nst1 = 0, nfl1 = 0, nboth = 0, nhz0 = 0;
  vec_t tv [11];

  always #5 clk = ~clk;

  // R-type funct3 -> ALU code; the jalr opcode with funct3=001 is a bench-only jalr that also claims to be a load
  function automatic ctl_t dec(input logic [31:0] i);
    ctl_t c;
    logic [2:0] f3;
    c = '0;
    f3 = i[14:12];
    case (i[6:0])
      7'b0110011: begin
        c.rw = 1'b1;
        c.ac = f3 == 3'b000 ? (i[30] ? 3'b001 : 3'b000) : f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 :
               f3 == 3'b100 ? 3'b100 : f3 == 3'b010 ? 3'b101 : f3 == 3'b001 ? 3'b110 : 3'b111;
      end
      7'b0010011: begin c.rw = 1'b1; c.as = 1'b1; end
      7'b0000011: begin c.rw = 1'b1; c.rs = 2'b01; c.as = 1'b1; end
      7'b0100011: begin c.mw = 1'b1; c.as = 1'b1; c.is = 2'b01; end
      7'b1100011: begin c.br = 1'b1; c.ac = 3'b001; c.is = 2'b10; end
      7'b1101111: begin c.rw = 1'b1; c.rs = 2'b10; c.j = 1'b1; c.is = 2'b11; end
      7'b1100111: begin c.rw = 1'b1; c.rs = f3 == 3'b001 ? 2'b01 : 2'b10; c.jr = 1'b1; c.as = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return i_t(imm, rs1, 3'b000, rd, 7'h13);
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] rr(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  assign instr1 = imem[pc1[8:2]];
  assign instr0 = imem[pc0[8:2]];
  assign rdata1 = dm1[ar1[8:2]];
  assign rdata0 = dm0[ar0[8:2]];
  assign c1 = dec(id1);
  assign c0 = dec(id0);

  datapath_hz #(.XLEN(32), .RESET_PC(32'h0), .HAZ_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instrF(instr1), .readdataM(rdata1),
    .reg_writeD(c1.rw), .result_srcD(c1.rs), .mem_writeD(c1.mw), .branchD(c1.br), .jumpD(c1.j),
    .jalrD(c1.jr), .alu_controlD(c1.ac), .alu_srcD(c1.as), .imm_srcD(c1.is),
    .pcF(pc1), .instrD(id1), .mem_writeM(mw1), .aluresultM(ar1), .writedataM(wd1), .stall(st1), .flush(fl1)
  );

  datapath_hz #(.XLEN(32), .RESET_PC(32'h0), .HAZ_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .instrF(instr0), .readdataM(rdata0),
    .reg_writeD(c0.rw), .result_srcD(c0.rs), .mem_writeD(c0.mw), .branchD(c0.br), .jumpD(c0.j),
    .jalrD(c0.jr), .alu_controlD(c0.ac), .alu_srcD(c0.as), .imm_srcD(c0.is),
    .pcF(pc0), .instrD(id0), .mem_writeM(mw0), .aluresultM(ar0), .writedataM(wd0), .stall(st0), .flush(fl0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one cycle: sample on the falling edge, commit stores, count hazard events
  task automatic tick();
    @(negedge clk);
    if (mw1) dm1[ar1[8:2]] = wd1;
    if (mw0) dm0[ar0[8:2]] = wd0;
    nst1 += int'(st1);
    nfl1 += int'(fl1);
    nboth += int'(st1 && fl1);
    nhz0 += int'(st0 || fl0);
    if (pfl) pc_fl = pc1;
    pfl = fl1;
  endtask

  task automatic clr_imem();
    for (int i = 0; i < 128; i++) imem[i] = NOP;
  endtask

  task automatic start();
    reset = 1'b0;
    for (int i = 0; i < 128; i++) begin
      dm1[i] = '0;
      dm0[i] = '0;
    end
    dm1[0] = 32'h1234;
    dm0[0] = 32'h1234;
    nst1 = 0;
    nfl1 = 0;
    nboth = 0;
    pfl = 1'b0;
    pc_fl = '1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tv[0]  = '{7'h00, 3'b000, 12'd5,   12'd7,   32'd12};
    tv[1]  = '{7'h20, 3'b000, 12'd5,   12'd7,   32'hFFFF_FFFE};
    tv[2]  = '{7'h00, 3'b111, 12'h0F0, 12'h03C, 32'h0000_0030};
    tv[3]  = '{7'h00, 3'b110, 12'h0F0, 12'h00F, 32'h0000_00FF};
    tv[4]  = '{7'h00, 3'b100, 12'h0FF, 12'h0F0, 32'h0000_000F};
    tv[5]  = '{7'h00, 3'b010, 12'hFFD, 12'd2,   32'd1};
    tv[6]  = '{7'h00, 3'b010, 12'd2,   12'hFFD, 32'd0};
    tv[7]  = '{7'h00, 3'b001, 12'd3,   12'd4,   32'd48};
    tv[8]  = '{7'h00, 3'b101, 12'hFF0, 12'd4,   32'h0FFF_FFFF};
    tv[9]  = '{7'h00, 3'b000, 12'h7FF, 12'h7FF, 32'h0000_0FFE};
    tv[10] = '{7'h00, 3'b000, 12'hFFF, 12'd1,   32'd0};
    clr_imem();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc1, 32'h0);
    chk("rst_instrD", id1, NOP);
    chk("rst_memwrite", 32'(mw1), 32'h0);
    chk("rst_aluresult", ar1, 32'h0);
    chk("rst_writedata", wd1, 32'h0);
    chk("rst_stall", 32'(st1), 32'h0);
    chk("rst_flush", 32'(fl1), 32'h0);

    // ALU ops with back-to-back operands: rs1 forwarded from W, rs2 and store data from M
    for (int k = 0; k < 11; k++) begin
      clr_imem();
      imem[0] = addi(5'd1, 5'd0, tv[k].a);
      imem[1] = addi(5'd2, 5'd0, tv[k].b);
      imem[2] = rr(tv[k].f7, 5'd2, 5'd1, tv[k].f3, 5'd3);
      imem[3] = sw(5'd3, 5'd0, 12'h40);
      start();
      repeat (12) tick();
      chk($sformatf("alu_vec%0d", k), dm1[16], tv[k].exp);
    end

    // dependent add directly after its producer; HAZ_EN=0 copy sees the stale x1
    clr_imem();
    imem[0] = addi(5'd1, 5'd0, 12'd0);
    imem[4] = addi(5'd1, 5'd0, 12'd5);
    imem[5] = rr(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);
    imem[9] = sw(5'd2, 5'd0, 12'h44);
    start();
    repeat (16) tick();
    chk("fwd_m_x2", dm1[17], 32'd10);
    chk("fwd_no_stall", 32'(nst1), 32'd0);
    chk("nohaz_stale_x2", dm0[17], 32'd0);

    // load-use: one stall cycle then W forward of the load data
    clr_imem();
    imem[0] = i_t(12'h000, 5'd0, 3'b010, 5'd3, 7'h03);
    imem[1] = rr(7'h00, 5'd0, 5'd3, 3'b000, 5'd4);
    imem[2] = sw(5'd4, 5'd0, 12'h48);
    start();
    repeat (14) tick();
    chk("load_use_x4", dm1[18], 32'h1234);
    chk("load_use_stalls", 32'(nst1), 32'd1);

    // taken beq at 0x10: shadow at 0x14 must not store
    clr_imem();
    imem[0] = addi(5'd5, 5'd0, 12'd7);
    imem[4] = beq(5'd0, 5'd0, 13'd8);
    imem[5] = sw(5'd5, 5'd0, 12'h4C);
    imem[6] = sw(5'd5, 5'd0, 12'h50);
    start();
    repeat (16) tick();
    chk("br_flushes", 32'(nfl1), 32'd1);
    chk("br_pc", pc_fl, 32'h18);
    chk("br_shadow", dm1[19], 32'd0);
    chk("br_target", dm1[20], 32'd7);
    chk("nohaz_shadow", dm0[19], 32'd7);

    // jalr x1,0x101(x0) at 0x8: lands on 0x100 with link 0xC
    clr_imem();
    imem[0] = addi(5'd5, 5'd0, 12'd9);
    imem[2] = i_t(12'h101, 5'd0, 3'b000, 5'd1, 7'h67);
    imem[3] = sw(5'd5, 5'd0, 12'h54);
    imem[64] = sw(5'd1, 5'd0, 12'h58);
    start();
    repeat (16) tick();
    chk("jalr_pc", pc_fl, 32'h100);
    chk("jalr_link", dm1[22], 32'hC);
    chk("jalr_shadow", dm1[21], 32'd0);

    // jalr tagged as a load whose rd is used next: stall and flush together, the redirect wins
    clr_imem();
    imem[0] = addi(5'd5, 5'd0, 12'd9);
    imem[2] = i_t(12'h081, 5'd0, 3'b001, 5'd7, 7'h67);
    imem[3] = sw(5'd7, 5'd0, 12'h60);
    imem[32] = sw(5'd5, 5'd0, 12'h5C);
    start();
    repeat (16) tick();
    chk("fs_both", 32'(nboth), 32'd1);
    chk("fs_pc", pc_fl, 32'h80);
    chk("fs_shadow", dm1[24], 32'd0);
    chk("fs_target", dm1[23], 32'd9);

    // reset with three adds in flight: their writes are discarded, earlier values survive
    clr_imem();
    imem[0] = addi(5'd11, 5'd0, 12'h11);
    imem[1] = addi(5'd12, 5'd0, 12'h22);
    imem[2] = addi(5'd13, 5'd0, 12'h33);
    start();
    repeat (10) tick();
    imem[0] = addi(5'd11, 5'd0, 12'd1);
    imem[1] = addi(5'd12, 5'd0, 12'd2);
    imem[2] = addi(5'd13, 5'd0, 12'd3);
    start();
    repeat (3) tick();
    chk("pre_reset_alu", ar1, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_pc", pc1, 32'h0);
    chk("mid_rst_instrD", id1, NOP);
    chk("mid_rst_memwrite", 32'(mw1), 32'h0);
    chk("mid_rst_aluresult", ar1, 32'h0);
    chk("mid_rst_writedata", wd1, 32'h0);
    clr_imem();
    imem[0] = sw(5'd11, 5'd0, 12'h64);
    imem[1] = sw(5'd12, 5'd0, 12'h68);
    imem[2] = sw(5'd13, 5'd0, 12'h6C);
    start();
    repeat (12) tick();
    chk("rst_discard_x11", dm1[25], 32'h11);
    chk("rst_discard_x12", dm1[26], 32'h22);
    chk("rst_discard_x13", dm1[27], 32'h33);

    chk("nohaz_quiet", 32'(nhz0), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
